// File: rtl/ws2812_receiver.sv
// WS2812 line decoder: measures high pulses, assembles BITWIDTH-bit words,
// flags latch gaps and forwards the stream after its own word like a pixel.
module ws2812_receiver #(
  parameter int F_CLK     = 12_000_000,
  parameter int BITWIDTH  = 24,
  parameter int T_THRESH  = int'(64'd550 * 64'(F_CLK) / 64'd1_000_000_000),
  parameter int T_MAXHIGH = int'(64'd1500 * 64'(F_CLK) / 64'd1_000_000_000),
  parameter int T_RESET   = int'(64'd50000 * 64'(F_CLK) / 64'd1_000_000_000)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Din,
  output logic [BITWIDTH-1:0] Data,
  output logic                Valid,
  output logic                Latch,
  output logic                Error,
  output logic                Dout
);

  localparam int HW = $clog2(T_MAXHIGH + 2);
  localparam int LW = $clog2(T_RESET + 1);
  localparam int BW = $clog2(BITWIDTH + 1);

  localparam logic [HW-1:0] H_MAX  = HW'(T_MAXHIGH);
  localparam logic [HW-1:0] H_THR  = HW'(T_THRESH);
  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [LW-1:0] L_RST  = LW'(T_RESET);
  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(BITWIDTH - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  typedef enum logic [1:0] {
    S_SYNC,
    S_LOW,
    S_HIGH
  } state_e;

  state_e state_q, state_d;

  logic                s0_q, s1_q;
  logic [HW-1:0]       hcnt_q, hcnt_d, hinc;
  logic [LW-1:0]       lcnt_q, lcnt_d, linc;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [BITWIDTH-1:0] word_q, word_d;
  logic [BITWIDTH-1:0] data_q, data_d;
  logic                fwd_q, fwd_d;
  logic                valid_q, valid_d;
  logic                latch_q, latch_d;
  logic                error_q, error_d;
  logic                dout_q;

  assign hinc = hcnt_q + H_ONE;
  assign linc = lcnt_q + L_ONE;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    data_d  = data_q;
    fwd_d   = fwd_q;
    valid_d = 1'b0;
    latch_d = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      S_SYNC: begin
        if (s1_q) begin
          lcnt_d = '0;
        end else if (linc >= L_RST) begin
          // already a full gap: park saturated so no Latch
          lcnt_d  = L_RST;
          state_d = S_LOW;
        end else begin
          lcnt_d = linc;
        end
      end
      S_LOW: begin
        if (s1_q) begin
          state_d = S_HIGH;
          hcnt_d  = H_ONE;
          lcnt_d  = '0;
        end else if (lcnt_q != L_RST) begin
          lcnt_d = linc;
          if (linc == L_RST) begin
            latch_d = 1'b1;
            fwd_d   = 1'b0;
            if (bcnt_q != '0) begin
              error_d = 1'b1;
              bcnt_d  = '0;
            end
          end
        end
      end
      S_HIGH: begin
        if (s1_q) begin
          if (hinc > H_MAX) begin
            error_d = 1'b1;
            bcnt_d  = '0;
            fwd_d   = 1'b0;
            hcnt_d  = '0;
            lcnt_d  = '0;
            state_d = S_SYNC;
          end else begin
            hcnt_d = hinc;
          end
        end else begin
          word_d[bcnt_q] = (hcnt_q >= H_THR);
          lcnt_d  = L_ONE;
          state_d = S_LOW;
          if (bcnt_q == B_LAST) begin
            data_d  = word_d;
            valid_d = 1'b1;
            bcnt_d  = '0;
            fwd_d   = 1'b1;
          end else begin
            bcnt_d = bcnt_q + B_ONE;
          end
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      state_q <= S_SYNC;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      data_q  <= '0;
      fwd_q   <= 1'b0;
      valid_q <= 1'b0;
      latch_q <= 1'b0;
      error_q <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      s0_q    <= Din;
      s1_q    <= s0_q;
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
      fwd_q   <= fwd_d;
      valid_q <= valid_d;
      latch_q <= latch_d;
      error_q <= error_d;
      dout_q  <= s1_q & fwd_q;
    end
  end

  assign Data  = data_q;
  assign Valid = valid_q;
  assign Latch = latch_q;
  assign Error = error_q;
  assign Dout  = dout_q;

endmodule

// File: tb/tb_ws2812_receiver.sv
// Bench for ws2812_receiver: drives WS2812 waveforms, scoreboards decoded
// words and checks latch/error/forwarding behaviour at 12 MHz timing.
module tb_ws2812_receiver;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        Din;
  logic [23:0] Data;
  logic        Valid;
  logic        Latch;
  logic        Error;
  logic        Dout;

  always #5 clk = ~clk;

  ws2812_receiver dut (
    .Clk    (clk),
    .Reset_n(Reset_n),
    .Din    (Din),
    .Data   (Data),
    .Valid  (Valid),
    .Latch  (Latch),
    .Error  (Error),
    .Dout   (Dout)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_fall = 0;
  bit lat_t_en = 1'b0;
  int dmode = 2;
  int n_valid = 0;
  int n_latch = 0;
  int n_error = 0;
  int n_le = 0;
  int n_ve = 0;
  logic [23:0] sbq[$];
  logic [3:0]  dh = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Dout should be Din seen three samples earlier while forwarding
  always @(negedge clk) begin
    cyc++;
    dh = {dh[2:0], Din};
    if (dmode == 0)
      chk("dout_zero", 32'(Dout), 32'd0);
    else if (dmode == 1)
      chk("dout_fwd", 32'(Dout), 32'(dh[3]));
    if (Valid === 1'b1) begin
      n_valid++;
      chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0)
        chk("data", 32'(Data), 32'(sbq.pop_front()));
    end
    if (Latch === 1'b1) begin
      n_latch++;
      if (lat_t_en)
        chk("latch_time", 32'(cyc - t_fall), 32'd602);
    end
    if (Error === 1'b1) n_error++;
    if (Latch === 1'b1 && Error === 1'b1) n_le++;
    if (Valid === 1'b1 && Error === 1'b1) n_ve++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic send_pulse(input int hi, input int lo);
    Din = 1'b1;
    hold(hi);
    Din = 1'b0;
    t_fall = cyc + 1;
    hold(lo);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(8, 7);
    else   send_pulse(4, 9);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 0; i < 24; i++) send_bit(w[i]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  32'(Data),  32'd0);
    chk({tag, "_valid"}, 32'(Valid), 32'd0);
    chk({tag, "_latch"}, 32'(Latch), 32'd0);
    chk({tag, "_error"}, 32'(Error), 32'd0);
    chk({tag, "_dout"},  32'(Dout),  32'd0);
  endtask

  initial begin
    int nv, nl, ne, nle, hi;
    logic [23:0] w;
    logic [9:0]  part;
    logic [11:0] part12;

    Reset_n = 1'b0;
    Din     = 1'b0;
    hold(2);
    chk_all_zero("rst");
    dmode   = 0;
    Reset_n = 1'b1;
    hold(600);

    sbq.push_back(24'hA5C31E);
    send_word(24'hA5C31E);
    hold(5);
    chk("t1_valid", 32'(n_valid), 32'd1);
    chk("t1_data", 32'(Data), 32'h00A5C31E);
    chk("t1_err", 32'(n_error), 32'd0);

    lat_t_en = 1'b1;
    hold(700);
    lat_t_en = 1'b0;
    chk("t2_latch", 32'(n_latch), 32'd1);
    chk("t2_err", 32'(n_error), 32'd0);

    sbq.push_back(24'h000001);
    send_word(24'h000001);
    dmode = 1;
    sbq.push_back(24'hFFFFFF);
    send_word(24'hFFFFFF);
    hold(700);
    dmode = 0;
    hold(10);
    chk("t3_valid", 32'(n_valid), 32'd3);
    chk("t3_data", 32'(Data), 32'h00FFFFFF);
    chk("t3_latch", 32'(n_latch), 32'd2);
    chk("t3_err", 32'(n_error), 32'd0);

    // pulse widths span 3..5 for zeros and 6..18 for ones
    dmode = 2;
    w = 24'h6B3D5A;
    sbq.push_back(w);
    for (int i = 0; i < 24; i++) begin
      if (w[i]) hi = (i == 1) ? 6 : 6 + (i * 7) % 13;
      else      hi = (i == 0) ? 5 : 3 + i % 3;
      send_pulse(hi, 9);
    end
    hold(700);
    chk("t4_tol_valid", 32'(n_valid), 32'd4);
    chk("t4_tol_err", 32'(n_error), 32'd0);

    nv = n_valid;
    nl = n_latch;
    ne = n_error;
    send_pulse(20, 9);
    chk("t4_long_err", 32'(n_error), 32'(ne + 1));
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    hold(600);
    chk("t4_no_valid", 32'(n_valid), 32'(nv));
    chk("t4_no_latch", 32'(n_latch), 32'(nl));
    sbq.push_back(24'h13579B);
    send_word(24'h13579B);
    hold(700);
    chk("t4_recover", 32'(n_valid), 32'(nv + 1));

    nv  = n_valid;
    nl  = n_latch;
    ne  = n_error;
    nle = n_le;
    part = 10'h2AB;
    for (int i = 0; i < 10; i++) send_bit(part[i]);
    hold(700);
    chk("t5_le", 32'(n_le), 32'(nle + 1));
    chk("t5_latch", 32'(n_latch), 32'(nl + 1));
    chk("t5_err", 32'(n_error), 32'(ne + 1));
    chk("t5_no_valid", 32'(n_valid), 32'(nv));
    sbq.push_back(24'hC0FFEE);
    send_word(24'hC0FFEE);
    hold(700);
    chk("t5_next", 32'(n_valid), 32'(nv + 1));
    chk("t5_next_err", 32'(n_error), 32'(ne + 1));

    nv = n_valid;
    part12 = 12'h9C5;
    for (int i = 0; i < 12; i++) send_bit(part12[i]);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    chk_all_zero("t6_rst");
    hold(600);
    sbq.push_back(24'h5EED42);
    send_word(24'h5EED42);
    hold(700);
    chk("t6_valid", 32'(n_valid), 32'(nv + 1));
    chk("t6_data", 32'(Data), 32'h005EED42);

    chk("sb_left", 32'(sbq.size()), 32'd0);
    chk("valid_err_overlap", 32'(n_ve), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
